// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and counter-width helper for the serial adder
package serial_adder_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done request bus carrying operands and result of the serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_fa.sv
// serial_adder_fa: one-bit full-adder cell
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell plus registered carry, LSB first
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = cnt_width(WIDTH)
) (
    input  logic            clk,
    input  logic            rst,
    serial_adder_if.slave   bus
);
    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [WIDTH-1:0]   sha_q, sha_d;
    logic [WIDTH-1:0]   shb_q, shb_d;
    logic [WIDTH-1:0]   psum_q, psum_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fa_s, fa_co, last;

    serial_adder_fa u_fa (
        .a  (sha_q[0]),
        .b  (shb_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        psum_d  = psum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        last    = cnt_q == CNT_W'(WIDTH - 1);
        if (state_q == RUN) begin
            sha_d   = sha_q >> 1;
            shb_d   = shb_q >> 1;
            psum_d  = {fa_s, psum_q[WIDTH-1:1]};
            carry_d = fa_co;
            cnt_d   = cnt_q + 1'b1;
            state_d = last ? DONE : RUN;
            sum_d   = last ? psum_d : sum_q;
            cout_d  = last ? fa_co : cout_q;
        end else if (!busy_q && bus.start) begin
            sha_d   = bus.a;
            shb_d   = bus.b;
            carry_d = bus.cin;
            cnt_d   = '0;
            state_d = RUN;
        end else begin
            state_d = IDLE;
        end
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sha_q   <= '0;
            shb_q   <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, multi-bit adder built around one one-bit full-adder cell plus a registered carry.
- Consumes the full-adder cell's sum and carry outputs, one bit per clock, LSB first.
- Accepts two WIDTH-bit operands and a carry-in through a start/done handshake, then presents a registered WIDTH-bit sum and carry-out.
- Trades latency for area against a ripple adder. Used where operands arrive infrequently.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range ≥ 2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not to be overridden).

Ports:
- clk  input  1  rising-edge clock; all state changes on this edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy==0.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high while an addition is in progress (RUN state).
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  result; valid from done onward.
- cout  output  1  final carry-out; valid from done onward.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers, carry register and counter all 0.
- rst has priority over every other input. Asserting rst mid-RUN aborts the operation: no done pulse is generated, and outputs return to their reset values on that edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start==1, load shA<=a, shB<=b, carry<=cin, cnt<=0; go to RUN.
  - RUN: full-adder cell is fed (shA[0], shB[0], carry). On each edge:
    - shift the cell's sum bit into the MSB of the partial-sum register;
    - shift shA and shB right by one;
    - carry <= cell carry;
    - cnt <= cnt+1.
    - When cnt==WIDTH-1 (last bit), go to DONE. On that same edge, sum <= completed partial sum (including the final bit) and cout <= final cell carry.
  - DONE: done=1 for exactly this cycle. Next state is IDLE. If start==1 in DONE, it is accepted exactly as in IDLE and the next state is RUN.
- busy is a registered decode of state==RUN. Start is accepted whenever busy==0 (IDLE or DONE).
- start while busy==1 is ignored: operands are not reloaded and the result is unaffected.
- Latency: counting the edge that accepts start as edge 1, done is high after edge WIDTH+1 (9 edges for WIDTH=8).
- Throughput: with start held high, one result every WIDTH+1 cycles.
- sum and cout change only on the completion edge or on reset. They hold their value through IDLE and through the following operation until that operation's completion edge.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Wrap-around is fully captured by cout, e.g. all-ones + 1.
- a, b and cin may change freely after the accepting edge.

Decomposition:
- Shared header or package: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the CNT_W derivation helper.
- Sub-module: instantiate the team's existing structural one-bit full-adder cell as the single datapath sub-module. No new sub-modules.
- Everything else (FSM, shift registers, counter, result registers) lives in serial_adder.

Test Plan (WIDTH=8):
1. Reset then idle. rst=1 for 2 cycles, then rst=0 with start=0 for 5 cycles -> busy=0, done=0, sum=8'h00, cout=0 throughout.
2. Start with a=8'hFF, b=8'h01, cin=0 -> busy high for 8 cycles; done pulses once after edge 9; sum=8'h00, cout=1.
3. Start with a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Then a=8'h3C, b=8'h42, cin=0 -> sum=8'h7E, cout=0; previous result held until the new done.
4. Start with a=8'h3C, b=8'h42, cin=0; pulse start with a=8'hFF, b=8'hFF at RUN cycle 3 -> ignored; result sum=8'h7E, cout=0; single done pulse.
5. Start with a=8'h12, b=8'h34; assert rst at RUN cycle 4 -> next edge gives busy=0, sum=0, cout=0, and no done pulse. A following operation 8'h12+8'h34 gives sum=8'h46, cout=0.
6. Back-to-back: hold start=1 with a=8'h80, b=8'h80, cin=0 -> done every 9 cycles, busy re-asserted the cycle after each done, sum=8'h00, cout=1 each time.
